// File: rtl/axis_frame_src.sv
// Frame-RAM playback source: replays SAMP samples as an AXI-Stream frame,
// NFRAMES times per start request, with a host load port usable outside a run.
module axis_frame_src #(
   parameter int SAMP        = 32,
   parameter int TDATA_WIDTH = 16,
   parameter int NFRAMES     = 4
) (
   input  logic                           clk,
   input  logic                           rstn,
   input  logic                           start,
   input  logic                           wr_en,
   input  logic [$clog2(SAMP)-1:0]        wr_addr,
   input  logic [TDATA_WIDTH-1:0]         wr_data,
   output logic [TDATA_WIDTH-1:0]         m_axis_tdata,
   output logic                           m_axis_tvalid,
   input  logic                           m_axis_tready,
   output logic                           m_axis_tlast,
   output logic                           busy,
   output logic                           done,
   output logic [$clog2(NFRAMES+1)-1:0]   frame_count
);

   // state  | meaning
   // IDLE   | after reset, RAM loadable, waiting for start
   // STREAM | emitting frames, RAM writes and start ignored
   // DONE   | run complete, done high, RAM loadable, start re-arms

   localparam int AW = $clog2(SAMP);
   localparam int FW = $clog2(NFRAMES+1);
   localparam logic [AW-1:0] LAST_IDX = AW'(SAMP-1);
   localparam logic [FW-1:0] NF       = FW'(NFRAMES);

   typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

   state_t                   state;
   logic [TDATA_WIDTH-1:0]   ram [SAMP];
   logic [AW-1:0]            idx;
   logic [AW-1:0]            idx_nxt;
   logic                     ram_we;
   logic                     xfer;
   logic                     last_frame;
   logic [TDATA_WIDTH-1:0]   first_word;

   assign ram_we     = wr_en && (state != STREAM);
   assign xfer       = m_axis_tvalid && m_axis_tready;
   assign idx_nxt    = idx + AW'(1);
   assign last_frame = (frame_count == NF - FW'(1));
   // A write to address 0 in the start cycle must reach the first beat.
   assign first_word = (ram_we && (wr_addr == '0)) ? wr_data : ram[0];

   // RAM has no reset so loaded frames survive a reset.
   always_ff @(posedge clk) begin
      if (ram_we) ram[wr_addr] <= wr_data;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state         <= IDLE;
         idx           <= '0;
         m_axis_tdata  <= '0;
         m_axis_tvalid <= 1'b0;
         m_axis_tlast  <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         frame_count   <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state         <= STREAM;
                  idx           <= '0;
                  m_axis_tdata  <= first_word;
                  m_axis_tvalid <= 1'b1;
                  m_axis_tlast  <= 1'b0;
                  busy          <= 1'b1;
                  done          <= 1'b0;
                  frame_count   <= '0;
               end
            end
            STREAM: begin
               if (xfer) begin
                  if (m_axis_tlast && frame_count != NF)
                     frame_count <= frame_count + FW'(1);
                  if (m_axis_tlast && last_frame) begin
                     state         <= DONE;
                     m_axis_tvalid <= 1'b0;
                     m_axis_tlast  <= 1'b0;
                     busy          <= 1'b0;
                     done          <= 1'b1;
                  end else begin
                     idx          <= idx_nxt;
                     m_axis_tdata <= ram[idx_nxt];
                     m_axis_tlast <= (idx_nxt == LAST_IDX);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axis_frame_src.sv
// Directed bench for axis_frame_src: default-parameter instance plus a
// SAMP=4 / NFRAMES=1 instance for the single-frame corner.
module tb_axis_frame_src;

   localparam int TOTAL = 128;

   logic        clk;
   logic        rstn;
   logic        start;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [15:0] wr_data;
   logic [15:0] m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tready;
   logic        m_axis_tlast;
   logic        busy;
   logic        done;
   logic [2:0]  frame_count;

   logic        start1;
   logic        wr_en1;
   logic [1:0]  wr_addr1;
   logic [15:0] wr_data1;
   logic [15:0] tdata1;
   logic        tvalid1;
   logic        tready1;
   logic        tlast1;
   logic        busy1;
   logic        done1;
   logic [0:0]  fc1;

   int n_chk;
   int n_fail;
   logic [15:0] mram [32];

   axis_frame_src dut (
      .clk(clk), .rstn(rstn), .start(start), .wr_en(wr_en),
      .wr_addr(wr_addr), .wr_data(wr_data),
      .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
      .busy(busy), .done(done), .frame_count(frame_count)
   );

   axis_frame_src #(.SAMP(4), .TDATA_WIDTH(16), .NFRAMES(1)) dut1 (
      .clk(clk), .rstn(rstn), .start(start1), .wr_en(wr_en1),
      .wr_addr(wr_addr1), .wr_data(wr_data1),
      .m_axis_tdata(tdata1), .m_axis_tvalid(tvalid1),
      .m_axis_tready(tready1), .m_axis_tlast(tlast1),
      .busy(busy1), .done(done1), .frame_count(fc1)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        st;
      logic        rdy;
      logic        wr;
      logic [4:0]  wa;
      logic [15:0] wd;
      logic        ev;
      logic [15:0] ed;
      logic        el;
      logic        eb;
   } vec_t;

   vec_t vt [10];

   function automatic vec_t mk(input logic st, input logic rdy, input logic wr,
                               input logic [4:0] wa, input logic [15:0] wd,
                               input logic ev, input logic [15:0] ed,
                               input logic el, input logic eb);
      vec_t v;
      v.st = st; v.rdy = rdy; v.wr = wr; v.wa = wa; v.wd = wd;
      v.ev = ev; v.ed = ed; v.el = el; v.eb = eb;
      return v;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic write_word(input logic [4:0] a, input logic [15:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      @(posedge clk); #1;
      wr_en = 1'b0;
      mram[a] = d;
   endtask

   // One full run from start; optional random stalls, mid-run start+write
   // injection, mid-run reset abort, and a write coinciding with start.
   task automatic play(input bit rnd, input int inj_beat, input int rst_beat,
                       input bit ws_en, input logic [4:0] ws_addr, input logic [15:0] ws_data);
      int b;
      int cyc;
      logic rdy;
      b = 0; cyc = 0;
      start = 1'b1; m_axis_tready = 1'b0;
      if (ws_en) begin
         wr_en = 1'b1; wr_addr = ws_addr; wr_data = ws_data;
         mram[ws_addr] = ws_data;
      end
      @(posedge clk); #1;
      start = 1'b0; wr_en = 1'b0;
      check("first_tvalid", 32'(m_axis_tvalid), 32'd1);
      check("first_tdata", 32'(m_axis_tdata), 32'(mram[0]));
      check("first_done", 32'(done), 32'd0);
      check("first_fc", 32'(frame_count), 32'd0);
      while (b < TOTAL && cyc < 2000) begin
         if (b == rst_beat) begin
            #1 rstn = 1'b0;
            #1;
            check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
            check("rst_tlast", 32'(m_axis_tlast), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_done", 32'(done), 32'd0);
            check("rst_fc", 32'(frame_count), 32'd0);
            #2 rstn = 1'b1;
            m_axis_tready = 1'b0;
            return;
         end
         rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         m_axis_tready = rdy;
         if (b == inj_beat) begin
            start = 1'b1; wr_en = 1'b1; wr_addr = 5'd5; wr_data = 16'hFFFF;
         end
         @(posedge clk); #1;
         start = 1'b0; wr_en = 1'b0;
         if (rdy) b++;
         cyc++;
         check("frame_count", 32'(frame_count), 32'(b / 32));
         if (b < TOTAL) begin
            check("tvalid", 32'(m_axis_tvalid), 32'd1);
            check("tdata", 32'(m_axis_tdata), 32'(mram[b % 32]));
            check("tlast", 32'(m_axis_tlast), 32'((b % 32) == 31));
            check("busy", 32'(busy), 32'd1);
            check("done_early", 32'(done), 32'd0);
         end else begin
            check("end_tvalid", 32'(m_axis_tvalid), 32'd0);
            check("end_tlast", 32'(m_axis_tlast), 32'd0);
            check("end_done", 32'(done), 32'd1);
            check("end_busy", 32'(busy), 32'd0);
         end
      end
      check("run_finished", 32'(b), 32'(TOTAL));
      if (!rnd) check("run_cycles", 32'(cyc), 32'(TOTAL));
      m_axis_tready = 1'b0;
   endtask

   initial begin
      n_chk = 0; n_fail = 0;
      clk = 1'b0; rstn = 1'b0;
      start = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; m_axis_tready = 1'b0;
      start1 = 1'b0; wr_en1 = 1'b0; wr_addr1 = '0; wr_data1 = '0; tready1 = 1'b0;

      #2;
      check("reset_tvalid", 32'(m_axis_tvalid), 32'd0);
      check("reset_tlast", 32'(m_axis_tlast), 32'd0);
      check("reset_tdata", 32'(m_axis_tdata), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_fc", 32'(frame_count), 32'd0);
      @(posedge clk); @(posedge clk); #1;
      rstn = 1'b1;

      for (int i = 0; i < 32; i++) write_word(5'(i), 16'(i + 100));
      for (int i = 0; i < 4; i++) begin
         wr_en1 = 1'b1; wr_addr1 = 2'(i); wr_data1 = 16'(16'h50 + i);
         @(posedge clk); #1;
         wr_en1 = 1'b0;
      end

      // Start, stalls, ignored start and ignored write inside STREAM.
      vt[0] = mk(1'b1, 1'b0, 1'b0, 5'd0, 16'd0, 1'b1, 16'd100, 1'b0, 1'b1);
      vt[1] = mk(1'b0, 1'b0, 1'b0, 5'd0, 16'd0, 1'b1, 16'd100, 1'b0, 1'b1);
      vt[2] = mk(1'b0, 1'b1, 1'b0, 5'd0, 16'd0, 1'b1, 16'd101, 1'b0, 1'b1);
      vt[3] = mk(1'b0, 1'b1, 1'b0, 5'd0, 16'd0, 1'b1, 16'd102, 1'b0, 1'b1);
      vt[4] = mk(1'b0, 1'b0, 1'b0, 5'd0, 16'd0, 1'b1, 16'd102, 1'b0, 1'b1);
      vt[5] = mk(1'b0, 1'b1, 1'b0, 5'd0, 16'd0, 1'b1, 16'd103, 1'b0, 1'b1);
      vt[6] = mk(1'b1, 1'b1, 1'b0, 5'd0, 16'd0, 1'b1, 16'd104, 1'b0, 1'b1);
      vt[7] = mk(1'b0, 1'b1, 1'b1, 5'd6, 16'd0, 1'b1, 16'd105, 1'b0, 1'b1);
      vt[8] = mk(1'b0, 1'b1, 1'b0, 5'd0, 16'd0, 1'b1, 16'd106, 1'b0, 1'b1);
      vt[9] = mk(1'b0, 1'b0, 1'b0, 5'd0, 16'd0, 1'b1, 16'd106, 1'b0, 1'b1);
      for (int i = 0; i < 10; i++) begin
         start = vt[i].st; m_axis_tready = vt[i].rdy;
         wr_en = vt[i].wr; wr_addr = vt[i].wa; wr_data = vt[i].wd;
         @(posedge clk); #1;
         start = 1'b0; wr_en = 1'b0;
         check($sformatf("vec%0d_tvalid", i), 32'(m_axis_tvalid), 32'(vt[i].ev));
         check($sformatf("vec%0d_tdata", i), 32'(m_axis_tdata), 32'(vt[i].ed));
         check($sformatf("vec%0d_tlast", i), 32'(m_axis_tlast), 32'(vt[i].el));
         check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vt[i].eb));
      end
      m_axis_tready = 1'b1;
      for (int i = 0; i < 300 && !done; i++) begin
         @(posedge clk); #1;
      end
      m_axis_tready = 1'b0;
      check("vec_run_done", 32'(done), 32'd1);
      check("vec_run_fc", 32'(frame_count), 32'd4);

      play(1'b0, -1, -1, 1'b0, 5'd0, 16'd0);
      play(1'b1, -1, -1, 1'b0, 5'd0, 16'd0);
      play(1'b0, 10, -1, 1'b0, 5'd0, 16'd0);
      play(1'b0, -1, 40, 1'b0, 5'd0, 16'd0);
      play(1'b0, -1, -1, 1'b0, 5'd0, 16'd0);

      write_word(5'd0, 16'hABCD);
      play(1'b0, -1, -1, 1'b0, 5'd0, 16'd0);
      play(1'b0, -1, -1, 1'b1, 5'd3, 16'h1234);

      // Single-frame instance: four beats, tlast on the fourth only.
      check("s1_done_before", 32'(done1), 32'd0);
      start1 = 1'b1; tready1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      for (int k = 0; k < 4; k++) begin
         check($sformatf("s1_tvalid%0d", k), 32'(tvalid1), 32'd1);
         check($sformatf("s1_tdata%0d", k), 32'(tdata1), 32'(16'h50 + k));
         check($sformatf("s1_tlast%0d", k), 32'(tlast1), 32'(k == 3));
         check($sformatf("s1_done%0d", k), 32'(done1), 32'd0);
         @(posedge clk); #1;
      end
      check("s1_end_tvalid", 32'(tvalid1), 32'd0);
      check("s1_end_done", 32'(done1), 32'd1);
      check("s1_end_busy", 32'(busy1), 32'd0);
      check("s1_end_fc", 32'(fc1), 32'd1);
      tready1 = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/axis_frame_src.md
AXIS_FRAME_SRC -- requirements
Module: axis_frame_src

Interface
REQ-001 SHALL have parameter SAMP, default 32, meaning samples per frame (power of two, >= 4).
REQ-002 SHALL have parameter TDATA_WIDTH, default 16, meaning sample width in bits.
REQ-003 SHALL have parameter NFRAMES, default 4, meaning frames emitted per start (>= 1).
REQ-004 SHALL have port clk  input  1  sole clock; all logic rising-edge.
REQ-005 SHALL have port rstn  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  single-cycle request to begin a playback run.
REQ-007 SHALL have port wr_en  input  1  frame-RAM load strobe.
REQ-008 SHALL have port wr_addr  input  $clog2(SAMP)  frame-RAM load address.
REQ-009 SHALL have port wr_data  input  TDATA_WIDTH  frame-RAM load data.
REQ-010 SHALL have port m_axis_tdata  output  TDATA_WIDTH  stream sample.
REQ-011 SHALL have port m_axis_tvalid  output  1  stream valid.
REQ-012 SHALL have port m_axis_tready  input  1  downstream ready.
REQ-013 SHALL have port m_axis_tlast  output  1  marks last sample of each frame.
REQ-014 SHALL have port busy  output  1  high while in STREAM.
REQ-015 SHALL have port done  output  1  high in DONE state.
REQ-016 SHALL have port frame_count  output  $clog2(NFRAMES+1)  frames fully sent in current or last run.

Function
REQ-017 SHALL implement FSM states IDLE, STREAM, DONE.
REQ-018 SHALL write wr_data to ram[wr_addr] on wr_en only in IDLE or DONE; wr_en in STREAM is ignored.
REQ-019 SHALL, on start in IDLE or DONE, enter STREAM next cycle, clear frame_count, deassert done.
REQ-020 SHALL ignore start while in STREAM.
REQ-021 SHALL drive all stream outputs from registers; first m_axis_tvalid high exactly 1 cycle after start sampled, carrying ram[0].
REQ-022 SHALL count a transfer only when m_axis_tvalid and m_axis_tready are both high on a rising edge.
REQ-023 SHALL hold m_axis_tdata and m_axis_tlast stable while m_axis_tvalid high and m_axis_tready low.
REQ-024 SHALL, after each transfer, present next sample on following cycle with no bubble (sustained 1 sample/cycle when tready held high).
REQ-025 SHALL emit samples ram[0..SAMP-1] in order per frame, sample index wrapping SAMP-1 -> 0 between frames.
REQ-026 SHALL assert m_axis_tlast exactly with sample index SAMP-1, never otherwise.
REQ-027 SHALL increment frame_count on each tlast transfer, saturating at NFRAMES.
REQ-028 SHALL, on tlast transfer with frame_count reaching NFRAMES, deassert m_axis_tvalid next cycle and enter DONE.
REQ-029 SHALL keep done high in DONE until next start; start in DONE behaves as start in IDLE (REQ-019, REQ-021).
REQ-030 SHALL write and start in the same cycle in IDLE/DONE: write completes, stream begins; written value visible if address reached later.
REQ-031 SHALL never deassert m_axis_tvalid mid-run except via reset (no valid withdrawal).

Reset
REQ-032 SHALL, when rstn low, asynchronously force IDLE, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, busy=0, done=0, frame_count=0, sample index=0.
REQ-033 SHALL not clear frame-RAM on reset; contents persist across reset.
REQ-034 SHALL, on reset asserted mid-run, abort the run immediately; no partial frame resumes after release.
REQ-035 SHALL release reset synchronously usable: first start accepted on any edge where rstn high.

Verification
REQ-036 Load ram[i]=i+100 for i=0..31, start, tready=1 -> 128 contiguous beats, data 100..131 repeating, tlast on beats 31/63/95/127, done high cycle after beat 127, frame_count=4.
REQ-037 Same load, tready toggled pseudo-randomly 50% -> identical beat sequence, tdata/tlast stable during every stall, no dropped/duplicated sample.
REQ-038 Start pulsed at beat 10 of run and wr_en with wr_addr=5 wr_data=0xFFFF during STREAM -> start ignored, frame 2 beat 5 still 105.
REQ-039 rstn driven low at beat 40 -> tvalid=0 same time step, busy/done/frame_count=0; after release and start, run restarts at ram[0]=100 with RAM intact.
REQ-040 From DONE, write ram[0]=0xABCD then start -> tvalid 1 cycle later with tdata=0xABCD, done=0, frame_count=0.
REQ-041 NFRAMES=1, SAMP=4, tready=1 -> exactly 4 beats, tlast only on 4th, done next cycle.
